// File: rtl/io_timer_pkg.sv
// Shared definitions for the io_timer block: register offsets, CTRL layout,
// reset values and the STATUS byte formatter.
package io_timer_pkg;

    localparam logic [2:0] OFF_CNT_LO = 3'd0;
    localparam logic [2:0] OFF_CNT_HI = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;

    localparam int unsigned STATUS_UF_BIT = 0;

    // CTRL register, bit3..bit0
    typedef struct packed {
        logic nsel;
        logic cont;
        logic ie;
        logic run;
    } ctrl_t;

    localparam ctrl_t       CTRL_RESET = '0;
    localparam logic [15:0] CNT_RESET  = 16'hFFFF;

    // STATUS read value: bit7 RUN, bit0 UF, all others zero
    function automatic logic [7:0] status_byte(input logic run, input logic uf);
        return {run, 6'b000000, uf};
    endfunction

endpackage

// File: rtl/io_prescaler.sv
// Modulo-PRESCALE counter with enable and synchronous clear; tick marks the
// enabled cycle in which the count sits at its terminal value.
module io_prescaler #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0]    LAST = W'(PRESCALE - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    // Advance while enabled, wrap after the terminal value, clear on request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit countdown timer with irq/nmi routing for the cpu6502
// bus. Holds the register file, counter, underflow flag and read mux.
module io_timer
    import io_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       write,
    input  logic [2:0] addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq,
    output logic       nmi
);

    logic [15:0] cnt;
    logic [7:0]  latch_lo;
    logic [7:0]  latch_hi;
    logic [7:0]  hi_snap;
    ctrl_t       ctrl;
    ctrl_t       ctrl_wdata;
    logic        uf;

    logic wr_en, rd_en;
    logic wr_lo, wr_hi, wr_ctrl, wr_status;
    logic tick, tick_eff, underflow;

    assign wr_en     = cs && write;
    assign rd_en     = cs && !write;
    assign wr_lo     = wr_en && (addr == OFF_CNT_LO);
    assign wr_hi     = wr_en && (addr == OFF_CNT_HI);
    assign wr_ctrl   = wr_en && (addr == OFF_CTRL);
    assign wr_status = wr_en && (addr == OFF_STATUS);
    assign ctrl_wdata = ctrl_t'(data_i[3:0]);

    io_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.run),
        .clr   (wr_hi),
        .tick  (tick)
    );

    // A tick is dropped when a reload or a RUN-clearing CTRL write lands on it
    assign tick_eff  = tick && !wr_hi && !(wr_ctrl && !ctrl_wdata.run);
    assign underflow = tick_eff && (cnt == 16'h0000);

    // Register file, countdown, reload and underflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt                  <= CNT_RESET;
            {latch_hi, latch_lo} <= CNT_RESET;
            ctrl                 <= CTRL_RESET;
            uf                   <= 1'b0;
            hi_snap              <= 8'h00;
        end else begin
            if (wr_lo) begin
                latch_lo <= data_i;
            end

            if (wr_hi) begin
                latch_hi <= data_i;
                cnt      <= {data_i, latch_lo};
            end else if (tick_eff) begin
                if (cnt != 16'h0000) begin
                    cnt <= cnt - 16'd1;
                end else if (ctrl.cont) begin
                    cnt <= {latch_hi, latch_lo};
                end
            end

            if (wr_ctrl) begin
                ctrl <= ctrl_wdata;
            end else if (underflow && !ctrl.cont) begin
                ctrl.run <= 1'b0;
            end

            // underflow and wr_hi are exclusive, so set-over-clear holds
            if (underflow) begin
                uf <= 1'b1;
            end else if (wr_hi || (wr_status && data_i[STATUS_UF_BIT])) begin
                uf <= 1'b0;
            end

            if (rd_en && (addr == OFF_CNT_LO)) begin
                hi_snap <= cnt[15:8];
            end
        end
    end

    assign irq = uf && ctrl.ie && !ctrl.nsel;
    assign nmi = uf && ctrl.ie && ctrl.nsel;

    // Read mux, driven only during a selected read cycle
    always_comb begin
        data_o = 8'h00;
        if (rd_en) begin
            case (addr)
                OFF_CNT_LO: data_o = cnt[7:0];
                OFF_CNT_HI: data_o = hi_snap;
                OFF_CTRL:   data_o = {4'b0000, ctrl};
                OFF_STATUS: data_o = status_byte(ctrl.run, uf);
                default:    data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus randomized
// load/mode/elapsed-time trials checked against an arithmetic timing model.
module tb_io_timer;

    localparam int unsigned P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       write;
    logic [2:0] addr;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       irq;
    logic       nmi;

    int unsigned cyc   = 0;
    int unsigned start = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;

    int unsigned s_j;
    logic        s_irq;
    logic        s_nmi;

    io_timer #(.PRESCALE(P)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .write  (write),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .irq    (irq),
        .nmi    (nmi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; data_i = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    // Sample data_o, irq, nmi mid-cycle; the read strobe spans the next edge
    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b0; addr = a;
        #1;
        d = data_o; s_irq = irq; s_nmi = nmi; s_j = cyc - start;
        @(posedge clk);
        #1;
        cs = 1'b0;
    endtask

    // Return just after edge number j counted from the run start
    task automatic wait_edges(input int unsigned j);
        int unsigned guard = 0;
        while ((cyc - start) < j) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 50000) begin
                chk("wait_timeout", 16'd1, 16'd0);
                break;
            end
        end
    endtask

    // Stop, load n, then start with ctrl; edge counting restarts at the CTRL write
    task automatic load_run(input logic [15:0] n, input logic [7:0] c);
        wr(3'd2, 8'h00);
        wr(3'd0, n[7:0]);
        wr(3'd1, n[15:8]);
        wr(3'd2, c);
        start = cyc;
    endtask

    // Counter state j clocks after starting from a fresh load of n:
    // t = j / P decrements have happened; underflow needs n+1 of them.
    task automatic model(input int unsigned n, input bit cont, input int unsigned j,
                         output int unsigned e_cnt, output bit e_uf, output bit e_run);
        int unsigned t = j / P;
        if (cont) begin
            e_cnt = n - (t % (n + 1));
            e_uf  = (t >= n + 1);
            e_run = 1'b1;
        end else if (t <= n) begin
            e_cnt = n - t;
            e_uf  = 1'b0;
            e_run = 1'b1;
        end else begin
            e_cnt = 0;
            e_uf  = 1'b1;
            e_run = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]  d, lo, hi;
        int unsigned n, j, e_cnt;
        bit          e_uf, e_run, ie, cont, nsel;
        logic [7:0]  c;

        reset = 1'b0; cs = 1'b0; write = 1'b0; addr = 3'd0; data_i = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_nmi", {15'd0, nmi}, 16'd0);
        rd(3'd1, d); chk("rst_hi_snap", {8'd0, d}, 16'h0000);
        rd(3'd0, d); chk("rst_cnt_lo", {8'd0, d}, 16'h00FF);
        rd(3'd1, d); chk("rst_cnt_hi", {8'd0, d}, 16'h00FF);
        rd(3'd2, d); chk("rst_ctrl", {8'd0, d}, 16'h0000);
        rd(3'd3, d); chk("rst_status", {8'd0, d}, 16'h0000);

        // One-shot: load 3, RUN|IE -> irq after 16 clocks, RUN cleared
        load_run(16'h0003, 8'h03);
        wait_edges(15);
        chk("oneshot_irq_early", {15'd0, irq}, 16'd0);
        wait_edges(16);
        chk("oneshot_irq", {15'd0, irq}, 16'd1);
        rd(3'd3, d); chk("oneshot_status", {8'd0, d}, 16'h0001);

        // Continuous: load 1 -> UF every 8 clocks; clear on underflow edge loses
        load_run(16'h0001, 8'h07);
        wait_edges(7);
        rd(3'd3, d); chk("cont_status_pre", {8'd0, d}, 16'h0080);
        rd(3'd3, d); chk("cont_status_uf", {8'd0, d}, 16'h0081);
        chk("cont_irq", {15'd0, s_irq}, 16'd1);
        wait_edges(9);
        wr(3'd3, 8'h01);
        rd(3'd3, d); chk("cont_clear", {8'd0, d}, 16'h0080);
        chk("cont_irq_clear", {15'd0, s_irq}, 16'd0);
        wait_edges(15);
        wr(3'd3, 8'h01);
        rd(3'd3, d); chk("cont_clear_vs_set", {8'd0, d}, 16'h0081);
        rd(3'd0, d); chk("cont_reload_lo", {8'd0, d}, 16'h0001);

        // NMI route
        load_run(16'h0000, 8'h0B);
        wait_edges(4);
        rd(3'd3, d); chk("nmi_status", {8'd0, d}, 16'h0001);
        chk("nmi_level", {15'd0, s_nmi}, 16'd1);
        chk("nmi_irq_low", {15'd0, s_irq}, 16'd0);
        wait_edges(10);
        chk("nmi_held", {15'd0, nmi}, 16'd1);
        wr(3'd3, 8'h01);
        chk("nmi_drop", {15'd0, nmi}, 16'd0);

        // Coherent 16-bit read across a borrow
        load_run(16'h0100, 8'h01);
        wait_edges(2);
        rd(3'd0, d); chk("coh_lo", {8'd0, d}, 16'h0000);
        wait_edges(10);
        rd(3'd1, d); chk("coh_hi", {8'd0, d}, 16'h0001);
        rd(3'd0, d); chk("coh_lo_later", {8'd0, d}, 16'h00FE);

        // Reload write colliding with a tick
        load_run(16'h0010, 8'h01);
        wait_edges(4);
        wr(3'd0, 8'h20);
        wait_edges(7);
        wr(3'd1, 8'h00);
        start = cyc;
        rd(3'd0, d); chk("coll_lo", {8'd0, d}, 16'h0020);
        rd(3'd1, d); chk("coll_hi", {8'd0, d}, 16'h0000);
        wait_edges(5);
        rd(3'd0, d); chk("coll_after_tick", {8'd0, d}, 16'h001F);
        for (int unsigned k = 4; k < 8; k++) begin
            rd(3'(k), d); chk("unmapped_read", {8'd0, d}, 16'h0000);
        end

        // Randomized load / mode / elapsed time
        for (int unsigned it = 0; it < 10; it++) begin
            n    = (it % 2 == 0) ? $urandom_range(0, 12) : $urandom_range(250, 270);
            ie   = 1'($urandom);
            cont = 1'($urandom);
            nsel = 1'($urandom);
            c    = {4'b0000, nsel, cont, ie, 1'b1};
            load_run(16'(n), c);
            j = $urandom_range(0, 3 * (n + 1) * P);
            wait_edges(j);
            rd(3'd0, lo);
            model(n, cont, s_j, e_cnt, e_uf, e_run);
            rd(3'd1, hi);
            chk("rand_cnt", {hi, lo}, 16'(e_cnt));
            rd(3'd3, d);
            model(n, cont, s_j, e_cnt, e_uf, e_run);
            chk("rand_status", {8'd0, d}, {8'd0, e_run, 6'd0, e_uf});
            chk("rand_irq", {15'd0, s_irq}, {15'd0, e_uf & ie & ~nsel});
            chk("rand_nmi", {15'd0, s_nmi}, {15'd0, e_uf & ie & nsel});
        end

        // Reset asserted mid-count, with an interrupt pending
        load_run(16'h0000, 8'h03);
        wait_edges(5);
        chk("pre_reset_irq", {15'd0, irq}, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_irq", {15'd0, irq}, 16'd0);
        chk("async_reset_nmi", {15'd0, nmi}, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = cyc;
        rd(3'd2, d); chk("post_reset_ctrl", {8'd0, d}, 16'h0000);
        rd(3'd0, d); chk("post_reset_lo", {8'd0, d}, 16'h00FF);
        wait_edges(20);
        rd(3'd3, d); chk("post_reset_status", {8'd0, d}, 16'h0000);
        chk("post_reset_irq", {15'd0, s_irq}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
